pairing_job_ctrl: RTL and testbench
===================================

# pairing_job_ctrl

Host-facing job sequencer for the pairing core. It accepts operand words over a valid/ready stream, writes them into the shared operand RAM, and releases the microcode FSM from reset. It then waits for `done` and streams the result words back out of RAM. It owns RAM port B except while the core is running, and optionally enforces a run-time watchdog.

## Interface
- `WIDTH`, 198, RAM word / field-element width in bits
- `ADDR_W`, 6, RAM address width
- `IN_BASE`, 6'd0, first RAM address written with operands
- `IN_WORDS`, 4, operand words per job (x1, y1, x2, y2 order)
- `OUT_BASE`, 6'd10, first RAM address holding the result
- `OUT_WORDS`, 6, result words per job
- `TIMEOUT`, 20'd600000, watchdog limit in cycles (only with `PAIRING_JOB_WDOG_EN`)

- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `in_valid`  in  1  operand word present
- `in_ready`  out  1  controller accepts operand word
- `in_data`  in  WIDTH  operand word
- `out_valid`  out  1  result word present
- `out_ready`  in  1  sink accepts result word
- `out_data`  out  WIDTH  result word (registered)
- `core_reset`  out  1  drives FSM `reset`; high except in RUN
- `core_done`  in  1  FSM `done` (level, registered in FSM)
- `ram_sel`  out  1  1 = controller owns RAM port B, 0 = FSM owns it
- `ram_addr`  out  ADDR_W  controller port-B address
- `ram_we`  out  1  controller port-B write enable
- `ram_wdata`  out  WIDTH  equals `in_data`
- `ram_rdata`  in  WIDTH  port-B read data, 1-cycle synchronous latency
- `busy`  out  1  state != IDLE
- `err`  out  1  sticky watchdog error

## Operation
- States: IDLE, LOAD, RUN, RD, CAP, HOLD.
- IDLE: `in_ready`=1. An accepted word writes `IN_BASE`, sets idx=1, clears `err`, and moves to LOAD. If `IN_WORDS`==1, it moves straight to RUN.
- LOAD: `in_ready`=1. Each accepted word writes `IN_BASE`+idx. On the accept with idx==`IN_WORDS`-1 it moves to RUN.
- Write path: `ram_we` = `in_valid` & `in_ready`, combinational. `ram_addr` = `IN_BASE`+idx.
- RUN: `core_reset`=0, `ram_sel`=0, `in_ready`=0. When `core_done`=1 it moves to RD with idx=0.
- RD: drives `ram_addr`=`OUT_BASE`+idx with `ram_we`=0, then moves to CAP.
- CAP: latches `out_data`<=`ram_rdata`, sets `out_valid`=1, then moves to HOLD.
- HOLD: holds `out_valid` and `out_data` stable until `out_ready`. On the handshake it clears `out_valid`. If idx==`OUT_WORDS`-1 it goes to IDLE; otherwise idx++ and it goes to RD.
- `core_reset` and `ram_sel` are decoded combinationally from state: both are 1 in every state except RUN. Re-asserting reset freezes the FSM, so RAM contents survive for unload.
- `core_done` is ignored outside RUN.
- `in_valid` asserted outside IDLE/LOAD is not accepted and produces no RAM write.
- `reset` at any point returns to IDLE. The partial job is discarded and no result is emitted.
- Arithmetic:
  - idx is ADDR_W bits.
  - Address sums wrap modulo 2^ADDR_W.
  - The watchdog counter is 20 bits and saturates.

## Timing
- Reset values:
  - State IDLE; `in_ready`=1 and `busy`=0 (both combinational from IDLE).
  - `out_valid`=0, `out_data`=0, `err`=0.
  - `core_reset`=1, `ram_sel`=1, `ram_we`=0.
- Load: one word per cycle at full rate. The cycle after the last accept, the block is in RUN and `core_reset`=0.
- RUN exit: the cycle after `core_done` is sampled high, the block is in RD and `core_reset`=1.
- Unload:
  - The first `out_valid` rises 2 cycles after RD entry.
  - With `out_ready` tied high, each word takes 3 cycles, so each result word takes 3 cycles.
- Job end: IDLE is entered the cycle after the last output handshake. A new operand can be accepted in that same IDLE cycle.

## Configuration
- `PAIRING_JOB_WDOG_EN` defined:
  - A cycle counter clears on RUN entry and increments while in RUN.
  - If it reaches `TIMEOUT` without `core_done`, the block sets `err`=1 and returns to IDLE. `core_reset` reasserts and no output is produced.
  - `err` holds until the next accepted operand word or `reset`.
- Not defined: there is no counter, `err` is tied 0, and RUN waits indefinitely.
- If `core_done` and the timeout occur in the same cycle, `core_done` wins and the job unloads normally.

## Structure
- Shared package `pairing_pkg`: state encoding enum, default `WIDTH`/`ADDR_W`, RAM map constants (`IN_BASE`, `OUT_BASE`, word counts).
- One sub-module, `pairing_job_wdog` (watchdog counter + compare), instantiated only under `PAIRING_JOB_WDOG_EN`.

## Test plan
- Full job:
  - Stimulus: 4 words 0x1,0x2,0x3,0x4 at full rate; FSM model raises done 50 cycles after release; RAM model preloads 0x10..0x15 at addresses 10..15.
  - Required: RAM writes at 0..3, `core_reset` low for exactly the RUN span, 6 output words 0x10..0x15 in order.
- Backpressure: `out_ready` toggled 1/0 every cycle → `out_data` stable while `out_valid` & !`out_ready`; no word dropped or duplicated.
- Input gaps: `in_valid` with 3 idle cycles between words → exactly 4 writes, RUN entered the cycle after the 4th accept.
- Input during RUN: `in_valid`=1 held in RUN → `in_ready`=0, `ram_we`=0, `ram_sel`=0.
- Reset mid-job: `reset` after 2 loaded words, then a fresh 4-word job → the fresh job writes addresses 0..3 and completes normally.
- Watchdog (macro on, `TIMEOUT`=100): done never asserted → `err`=1 and state IDLE 100 cycles after RUN entry, no `out_valid`; the next accepted word clears `err`.

Source files
------------

// File: rtl/pairing_pkg.sv
// Shared definitions for the pairing job controller: state encoding and the default RAM map.
package pairing_pkg;

    localparam int DEF_WIDTH     = 198;
    localparam int DEF_ADDR_W    = 6;
    localparam int DEF_IN_BASE   = 0;
    localparam int DEF_IN_WORDS  = 4;
    localparam int DEF_OUT_BASE  = 10;
    localparam int DEF_OUT_WORDS = 6;
    localparam int DEF_TIMEOUT   = 600000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_RD   = 3'd3,
        ST_CAP  = 3'd4,
        ST_HOLD = 3'd5
    } job_state_t;

endpackage

// File: rtl/pairing_job_wdog.sv
// Run-time watchdog: counts cycles spent in RUN and flags expiry on the last allowed cycle.
module pairing_job_wdog #(
    parameter logic [19:0] TIMEOUT = 20'd600000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic expired
);

    logic [19:0] cnt;

    // Held at zero outside RUN, so every RUN entry starts from a cleared count.
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + 20'd1;
        end
    end

    assign expired = run && (cnt >= (TIMEOUT - 20'd1));

endmodule

// File: rtl/pairing_job_ctrl.sv
// Host-facing job sequencer: loads operands into RAM, runs the core, unloads results.
// Optional run-time watchdog enabled by defining PAIRING_JOB_WDOG_EN.
module pairing_job_ctrl
    import pairing_pkg::*;
#(
    parameter int                WIDTH     = DEF_WIDTH,
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] IN_BASE   = ADDR_W'(DEF_IN_BASE),
    parameter int                IN_WORDS  = DEF_IN_WORDS,
    parameter logic [ADDR_W-1:0] OUT_BASE  = ADDR_W'(DEF_OUT_BASE),
    parameter int                OUT_WORDS = DEF_OUT_WORDS,
    parameter logic [19:0]       TIMEOUT   = 20'(DEF_TIMEOUT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              core_reset,
    input  logic              core_done,
    output logic              ram_sel,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [WIDTH-1:0]  ram_wdata,
    input  logic [WIDTH-1:0]  ram_rdata,
    output logic              busy,
    output logic              err
);

    localparam logic [ADDR_W-1:0] IN_LAST  = ADDR_W'(IN_WORDS - 1);
    localparam logic [ADDR_W-1:0] OUT_LAST = ADDR_W'(OUT_WORDS - 1);

    job_state_t        state, state_next;
    logic [ADDR_W-1:0] idx, idx_next;
    logic              out_valid_next;
    logic              capture;
    logic              accept;
    logic              wdog_expired;

    assign accept    = in_valid && in_ready;
    assign ram_we    = accept;
    assign ram_wdata = in_data;

`ifdef PAIRING_JOB_WDOG_EN
    pairing_job_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .run     (state == ST_RUN),
        .expired (wdog_expired)
    );

    // A timeout only counts when done is not present in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (accept) begin
            err <= 1'b0;
        end else if ((state == ST_RUN) && !core_done && wdog_expired) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign wdog_expired   = 1'b0;
    assign err            = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            idx       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            out_valid <= out_valid_next;
            if (capture) begin
                out_data <= ram_rdata;
            end
        end
    end

    // Core reset and RAM ownership are released only while the core runs.
    always_comb begin
        state_next     = state;
        idx_next       = idx;
        out_valid_next = out_valid;
        capture        = 1'b0;
        in_ready       = 1'b0;
        core_reset     = 1'b1;
        ram_sel        = 1'b1;
        ram_addr       = IN_BASE + idx;
        busy           = (state != ST_IDLE);

        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                ram_addr = IN_BASE;
                if (in_valid) begin
                    idx_next   = ADDR_W'(1);
                    state_next = (IN_WORDS == 1) ? ST_RUN : ST_LOAD;
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (idx == IN_LAST) begin
                        state_next = ST_RUN;
                    end else begin
                        idx_next = idx + ADDR_W'(1);
                    end
                end
            end
            ST_RUN: begin
                core_reset = 1'b0;
                ram_sel    = 1'b0;
                if (core_done) begin
                    idx_next   = '0;
                    state_next = ST_RD;
                end else if (wdog_expired) begin
                    state_next = ST_IDLE;
                end
            end
            ST_RD: begin
                ram_addr   = OUT_BASE + idx;
                state_next = ST_CAP;
            end
            ST_CAP: begin
                capture        = 1'b1;
                out_valid_next = 1'b1;
                state_next     = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    if (idx == OUT_LAST) begin
                        state_next = ST_IDLE;
                    end else begin
                        idx_next   = idx + ADDR_W'(1);
                        state_next = ST_RD;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pairing_job_ctrl.sv
// Directed self-checking bench for pairing_job_ctrl with a behavioural RAM and core model.
module tb_pairing_job_ctrl;

    localparam int W  = 198;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          core_reset;
    logic          core_done = 1'b0;
    logic          ram_sel;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [W-1:0]  ram_wdata;
    logic [W-1:0]  ram_rdata;
    logic          busy;
    logic          err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pairing_job_ctrl #(
        .WIDTH   (W),
        .ADDR_W  (AW),
        .TIMEOUT (20'd100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .core_reset (core_reset),
        .core_done  (core_done),
        .ram_sel    (ram_sel),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .busy       (busy),
        .err        (err)
    );

    // RAM model: the result region 10..15 reads back res_base + offset.
    logic [W-1:0] mem [64];
    logic [W-1:0] res_base = '0;
    always @(posedge clk) begin
        if (ram_sel && ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_addr >= 6'd10 && ram_addr <= 6'd15)
            ram_rdata <= res_base + W'(ram_addr - 6'd10);
        else
            ram_rdata <= mem[ram_addr];
    end

    // Core model: done rises 50 cycles after release unless told to hang.
    int   fsm_cnt = 0;
    logic hang = 1'b0;
    always @(posedge clk) begin
        if (core_reset) begin
            fsm_cnt   <= 0;
            core_done <= 1'b0;
        end else begin
            fsm_cnt <= fsm_cnt + 1;
            if (fsm_cnt == 49 && !hang) core_done <= 1'b1;
        end
    end

    logic [AW-1:0] wr_addr_q[$];
    logic [W-1:0]  wr_data_q[$];
    logic [W-1:0]  out_q[$];
    int            cyc = 0;
    int            cr_low = 0;
    int            stab_viol = 0;
    int            wr_while_run = 0;
    int            p1 = 0;
    int            ov_gap = -1;
    logic          armed = 1'b0;
    logic          cr_prev = 1'b1;
    logic          ov_prev = 1'b0;
    logic          stall_prev = 1'b0;
    logic [W-1:0]  data_prev = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_sel && ram_we) begin
            wr_addr_q.push_back(ram_addr);
            wr_data_q.push_back(ram_wdata);
        end
        if (!ram_sel && ram_we) wr_while_run <= wr_while_run + 1;
        if (!core_reset) cr_low <= cr_low + 1;
        if (core_reset && !cr_prev) begin
            p1    <= cyc;
            armed <= 1'b1;
        end
        if (out_valid && !ov_prev && armed) begin
            ov_gap <= cyc - p1;
            armed  <= 1'b0;
        end
        if (stall_prev && (out_data !== data_prev)) stab_viol <= stab_viol + 1;
        if (out_valid && out_ready) out_q.push_back(out_data);
        stall_prev <= out_valid && !out_ready;
        data_prev  <= out_data;
        cr_prev    <= core_reset;
        ov_prev    <= out_valid;
    end

    task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] base, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = base + W'(i);
            checkOutput("in_ready_load", in_ready, 1'b1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (i < n - 1) repeat (gap) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic waitUnload(input logic toggle);
        bit done_seen = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 800 && !done_seen; c++) begin
            @(posedge clk); #1;
            if (toggle) out_ready = ~out_ready;
            if (out_q.size() == 6) begin
                checkOutput("idle_after_last", busy, 1'b0);
                done_seen = 1;
            end
        end
        if (!done_seen) checkOutput("unload_timeout", W'(out_q.size()), W'(6));
        out_ready = 1'b1;
    endtask

    task automatic checkResults(input logic [W-1:0] in_base, input logic [W-1:0] out_base);
        checkOutput("wr_count", W'(wr_addr_q.size()), W'(4));
        for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
            checkOutput("wr_addr", W'(wr_addr_q[i]), W'(i));
            checkOutput("wr_data", wr_data_q[i], in_base + W'(i));
        end
        checkOutput("out_count", W'(out_q.size()), W'(6));
        for (int i = 0; i < 6 && i < out_q.size(); i++)
            checkOutput("out_data", out_q[i], out_base + W'(i));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        int cr0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        checkOutput("rst_in_ready", in_ready, 1'b1);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_out_data", out_data, '0);
        checkOutput("rst_err", err, 1'b0);
        checkOutput("rst_core_reset", core_reset, 1'b1);
        checkOutput("rst_ram_sel", ram_sel, 1'b1);
        checkOutput("rst_ram_we", ram_we, 1'b0);

        $display("[TB] full job");
        wr_addr_q.delete(); wr_data_q.delete(); out_q.delete();
        res_base = W'(16'h10);
        cr0 = cr_low;
        applyStimulus(W'(1), 4, 0);
        checkOutput("run_core_reset", core_reset, 1'b0);
        checkOutput("run_busy", busy, 1'b1);
        checkOutput("run_in_ready", in_ready, 1'b0);
        waitUnload(1'b0);
        checkResults(W'(1), W'(16'h10));
        checkOutput("run_span", W'(cr_low - cr0), W'(51));
        checkOutput("first_valid_gap", W'(ov_gap), W'(2));

        $display("[TB] backpressure");
        wr_addr_q.delete(); wr_data_q.delete(); out_q.delete();
        res_base = W'(16'h20);
        applyStimulus(W'(16'hA), 4, 0);
        waitUnload(1'b1);
        checkResults(W'(16'hA), W'(16'h20));
        checkOutput("stable_when_stalled", W'(stab_viol), W'(0));

        $display("[TB] input gaps and input during run");
        wr_addr_q.delete(); wr_data_q.delete(); out_q.delete();
        res_base = W'(16'h30);
        applyStimulus(W'(5), 4, 3);
        checkOutput("gap_run_entry", core_reset, 1'b0);
        in_valid = 1'b1;
        in_data  = W'(16'hDEAD);
        #1;
        checkOutput("run_in_ready_held", in_ready, 1'b0);
        checkOutput("run_ram_we", ram_we, 1'b0);
        checkOutput("run_ram_sel", ram_sel, 1'b0);
        repeat (5) @(posedge clk);
        #1 in_valid = 1'b0;
        waitUnload(1'b0);
        checkResults(W'(5), W'(16'h30));
        checkOutput("wr_while_run", W'(wr_while_run), W'(0));

        $display("[TB] reset mid-job");
        wr_addr_q.delete(); wr_data_q.delete(); out_q.delete();
        applyStimulus(W'(16'h41), 2, 0);
        checkOutput("mid_busy", busy, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("mid_rst_busy", busy, 1'b0);
        checkOutput("mid_rst_in_ready", in_ready, 1'b1);
        wr_addr_q.delete(); wr_data_q.delete(); out_q.delete();
        res_base = W'(16'h50);
        applyStimulus(W'(16'h31), 4, 0);
        waitUnload(1'b0);
        checkResults(W'(16'h31), W'(16'h50));

`ifdef PAIRING_JOB_WDOG_EN
        $display("[TB] watchdog");
        hang = 1'b1;
        out_q.delete();
        applyStimulus(W'(16'h61), 4, 0);
        repeat (99) begin
            @(posedge clk); #1;
        end
        checkOutput("wdog_busy_99", busy, 1'b1);
        checkOutput("wdog_err_99", err, 1'b0);
        @(posedge clk); #1;
        checkOutput("wdog_busy_100", busy, 1'b0);
        checkOutput("wdog_err_100", err, 1'b1);
        checkOutput("wdog_core_reset", core_reset, 1'b1);
        checkOutput("wdog_out_valid", out_valid, 1'b0);
        checkOutput("wdog_no_output", W'(out_q.size()), W'(0));
        in_valid = 1'b1;
        in_data  = W'(16'h77);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("wdog_err_clear", err, 1'b0);
        checkOutput("wdog_new_job", busy, 1'b1);
        hang  = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
`else
        checkOutput("err_tied_low", err, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
